alu_exec_unit: RTL and testbench
================================

ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 SHALL have parameter: XLEN, 32, operand/result width in bits.
REQ-002 SHALL have parameter: BUF_DEPTH, 2, output buffer entries (power of two, >=2).
REQ-003 SHALL have port: clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port: in_valid  input  1  uop presented.
REQ-006 SHALL have port: in_ready  output  1  unit can accept uop this cycle.
REQ-007 SHALL have ports: ctrl_adder input `CTRL_ADD_WIDTH and uop_is_add input 1, both from the ALU control decoder.
REQ-008 SHALL have ports: ctrl_logic input `CTRL_LOGIC_WIDTH and uop_is_logic input 1, both from the ALU control decoder.
REQ-009 SHALL have ports: rs1_data input XLEN, rs2_data input XLEN, imm input XLEN (sign-extended immediate).
REQ-010 SHALL have ports: res_valid output 1, res_ready input 1, res_data output XLEN.
REQ-011 SHALL have port: illegal_uop  output  1  sticky error flag.

Function
REQ-012 SHALL accept a uop when in_valid && in_ready; in_ready = buffer not full OR (res_ready && buffer full).
REQ-013 SHALL compute: `CTRL_ADD rs1+rs2; `CTRL_SUB rs1-rs2; `CTRL_ADDI rs1+imm; all modulo 2^XLEN, carry discarded.
REQ-014 SHALL compute: `CTRL_AND/OR/XOR on rs1,rs2; `CTRL_ANDI/ORI/XORI on rs1,imm.
REQ-015 SHALL register the result: earliest res_valid is the cycle after acceptance (latency 1) with an empty buffer.
REQ-016 SHALL hold res_data and res_valid stable while res_valid && !res_ready.
REQ-017 SHALL pop one entry on res_valid && res_ready; simultaneous push and pop keeps occupancy constant.
REQ-018 SHALL deliver results in acceptance order; no drop or duplication at buffer wrap-around.
REQ-019 SHALL treat a uop with both uop_is_add and uop_is_logic set, or neither set, or an unknown ctrl encoding, as illegal: result 0, still enqueued, illegal_uop set.
REQ-020 SHALL keep illegal_uop set until reset.
REQ-021 SHALL use buffer states EMPTY, PARTIAL and FULL; FULL deasserts in_ready unless a pop occurs the same cycle.

Reset
REQ-022 SHALL on reset: buffer empty, res_valid=0, res_data=0, illegal_uop=0, in_ready=0 while reset is asserted.
REQ-023 SHALL discard all buffered and in-flight uops on reset assertion mid-operation; in_ready=1 the first cycle after reset deassertion.

Configuration
REQ-024 SHALL, with ALU_EXEC_FLAGS_EN defined, add outputs res_zero (1), res_carry (1) and res_ovf (1), buffered alongside res_data.
REQ-025 SHALL define the flags: res_zero means result==0; res_carry means adder carry-out (for SUB, inverted borrow); res_ovf means signed overflow; carry and ovf are 0 for logic uops.
REQ-026 SHALL, without ALU_EXEC_FLAGS_EN, have no flag ports, no flag storage, and no other behaviour change.

Structure
REQ-027 SHALL take CTRL_* encodings, CTRL_ADD_WIDTH and CTRL_LOGIC_WIDTH from shared Execution_param.vh; the unit SHALL NOT redefine them.
REQ-028 SHALL place the output buffer in sub-module alu_res_buf (parameterised width and depth, push/pop/full/empty).
REQ-029 SHALL keep the datapath (adder, logic unit, result mux) combinational ahead of alu_res_buf.

Verification
REQ-030 SHALL cover: CTRL_ADD, rs1=0x7FFFFFFF, rs2=1, res_ready=1 -> res_valid next cycle, res_data=0x80000000; res_ovf=1 if flags enabled.
REQ-031 SHALL cover: CTRL_SUB, rs1=5, rs2=7 -> res_data=0xFFFFFFFE; CTRL_XORI, rs1=0xFF, imm=0xFFFFFFFF -> 0xFFFFFF00.
REQ-032 SHALL cover: res_ready=0, 3 back-to-back uops -> 2 accepted, in_ready=0 on the third; after release, results come out in order with no loss.
REQ-033 SHALL cover: full buffer, push and pop in the same cycle -> occupancy stays 2, in_ready=1.
REQ-034 SHALL cover: uop_is_add=1 and uop_is_logic=1 -> res_data=0, illegal_uop=1, flag persists across later legal uops.
REQ-035 SHALL cover: reset asserted asynchronously with 2 entries buffered -> res_valid=0 immediately, buffer empty after deassertion.

Source files
------------

// File: rtl/alu_exec_unit_pkg.sv
// Shared types and control encodings for the ALU execution unit.
// Encodings come from Execution_param.vh; this package only re-exports them.
package alu_exec_unit_pkg;

`include "Execution_param.vh"

    localparam int CTRL_ADD_W   = `CTRL_ADD_WIDTH;
    localparam int CTRL_LOGIC_W = `CTRL_LOGIC_WIDTH;

    localparam logic [CTRL_ADD_W-1:0] OP_ADD  = `CTRL_ADD;
    localparam logic [CTRL_ADD_W-1:0] OP_SUB  = `CTRL_SUB;
    localparam logic [CTRL_ADD_W-1:0] OP_ADDI = `CTRL_ADDI;

    localparam logic [CTRL_LOGIC_W-1:0] OP_AND  = `CTRL_AND;
    localparam logic [CTRL_LOGIC_W-1:0] OP_OR   = `CTRL_OR;
    localparam logic [CTRL_LOGIC_W-1:0] OP_XOR  = `CTRL_XOR;
    localparam logic [CTRL_LOGIC_W-1:0] OP_ANDI = `CTRL_ANDI;
    localparam logic [CTRL_LOGIC_W-1:0] OP_ORI  = `CTRL_ORI;
    localparam logic [CTRL_LOGIC_W-1:0] OP_XORI = `CTRL_XORI;

    typedef enum logic [1:0] {
        BUF_EMPTY   = 2'd0,
        BUF_PARTIAL = 2'd1,
        BUF_FULL    = 2'd2
    } buf_state_e;

    // Immediate forms of the logic ops take their second operand from imm.
    function automatic logic logic_uses_imm(input logic [CTRL_LOGIC_W-1:0] ctrl);
        return (ctrl == OP_ANDI) || (ctrl == OP_ORI) || (ctrl == OP_XORI);
    endfunction

endpackage

// File: rtl/alu_exec_unit_if.sv
// Uop-in / result-out bundle of the ALU execution unit.
// Flag signals exist only when ALU_EXEC_FLAGS_EN is defined.
interface alu_exec_if
    import alu_exec_unit_pkg::*;
#(
    parameter int XLEN = 32
) ();
    logic                    in_valid;
    logic                    in_ready;
    logic [CTRL_ADD_W-1:0]   ctrl_adder;
    logic                    uop_is_add;
    logic [CTRL_LOGIC_W-1:0] ctrl_logic;
    logic                    uop_is_logic;
    logic [XLEN-1:0]         rs1_data;
    logic [XLEN-1:0]         rs2_data;
    logic [XLEN-1:0]         imm;
    logic                    res_valid;
    logic                    res_ready;
    logic [XLEN-1:0]         res_data;
    logic                    illegal_uop;
`ifdef ALU_EXEC_FLAGS_EN
    logic                    res_zero;
    logic                    res_carry;
    logic                    res_ovf;
`endif

    modport master (
        output in_valid, ctrl_adder, uop_is_add, ctrl_logic, uop_is_logic,
        output rs1_data, rs2_data, imm, res_ready,
`ifdef ALU_EXEC_FLAGS_EN
        input  res_zero, res_carry, res_ovf,
`endif
        input  in_ready, res_valid, res_data, illegal_uop
    );

    modport slave (
        input  in_valid, ctrl_adder, uop_is_add, ctrl_logic, uop_is_logic,
        input  rs1_data, rs2_data, imm, res_ready,
`ifdef ALU_EXEC_FLAGS_EN
        output res_zero, res_carry, res_ovf,
`endif
        output in_ready, res_valid, res_data, illegal_uop
    );
endinterface

// File: rtl/Execution_param.vh
// Shared ALU control encodings used by the decoder and the execution units.
`ifndef EXECUTION_PARAM_VH
`define EXECUTION_PARAM_VH

`define CTRL_ADD_WIDTH   2
`define CTRL_ADD         2'd0
`define CTRL_SUB         2'd1
`define CTRL_ADDI        2'd2

`define CTRL_LOGIC_WIDTH 3
`define CTRL_AND         3'd0
`define CTRL_OR          3'd1
`define CTRL_XOR         3'd2
`define CTRL_ANDI        3'd3
`define CTRL_ORI         3'd4
`define CTRL_XORI        3'd5

`endif

// File: rtl/alu_res_buf.sv
// Small in-order result buffer with EMPTY/PARTIAL/FULL occupancy states.
// A push into a full buffer is honoured only when a pop happens the same cycle.
module alu_res_buf
    import alu_exec_unit_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    buf_state_e       state_q, state_d;
    logic             do_push, do_pop;

    assign empty   = (state_q == BUF_EMPTY);
    assign full    = (state_q == BUF_FULL);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            BUF_EMPTY: begin
                if (do_push) begin
                    state_d = BUF_PARTIAL;
                end
            end
            BUF_PARTIAL: begin
                if (do_push && !do_pop && (count_q == CNT_W'(DEPTH - 1))) begin
                    state_d = BUF_FULL;
                end else if (do_pop && !do_push && (count_q == CNT_W'(1))) begin
                    state_d = BUF_EMPTY;
                end
            end
            BUF_FULL: begin
                if (do_pop && !do_push) begin
                    state_d = BUF_PARTIAL;
                end
            end
            default: state_d = BUF_EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= BUF_EMPTY;
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: the head is masked to zero while empty.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign pop_data = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/alu_exec_unit.sv
// Single-cycle add/sub/logic execution unit feeding an in-order result buffer.
// Define ALU_EXEC_FLAGS_EN to add zero/carry/overflow flags to each result.
module alu_exec_unit
    import alu_exec_unit_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int BUF_DEPTH = 2
) (
    input  logic      clk,
    input  logic      reset,
    alu_exec_if.slave bus
);
`ifdef ALU_EXEC_FLAGS_EN
    localparam int ENTRY_W = XLEN + 3;
`else
    localparam int ENTRY_W = XLEN;
`endif

    logic               accept, pop;
    logic               buf_full, buf_empty;
    logic               is_sub, add_known, logic_known, illegal;
    logic [XLEN-1:0]    add_b, b_eff, add_sum;
    logic [XLEN-1:0]    logic_b, logic_res, result;
    logic [ENTRY_W-1:0] push_entry, head_entry;
    logic               illegal_q;

    // Adder: SUB is rs1 + ~rs2 + 1 so carry-out is the inverted borrow.
    assign is_sub    = (bus.ctrl_adder == OP_SUB);
    assign add_known = (bus.ctrl_adder == OP_ADD) || (bus.ctrl_adder == OP_SUB) ||
                       (bus.ctrl_adder == OP_ADDI);
    assign add_b     = (bus.ctrl_adder == OP_ADDI) ? bus.imm : bus.rs2_data;
    assign b_eff     = is_sub ? ~add_b : add_b;

`ifdef ALU_EXEC_FLAGS_EN
    logic [XLEN:0] add_full;
    logic          add_carry, add_ovf;
    logic          flag_zero, flag_carry, flag_ovf;

    assign add_full  = {1'b0, bus.rs1_data} + {1'b0, b_eff} + {{XLEN{1'b0}}, is_sub};
    assign add_sum   = add_full[XLEN-1:0];
    assign add_carry = add_full[XLEN];
    assign add_ovf   = (bus.rs1_data[XLEN-1] == b_eff[XLEN-1]) &&
                       (add_sum[XLEN-1] != bus.rs1_data[XLEN-1]);
`else
    assign add_sum   = bus.rs1_data + b_eff + {{(XLEN-1){1'b0}}, is_sub};
`endif

    assign logic_b = logic_uses_imm(bus.ctrl_logic) ? bus.imm : bus.rs2_data;

    always_comb begin
        logic_res   = '0;
        logic_known = 1'b1;
        case (bus.ctrl_logic)
            OP_AND, OP_ANDI: logic_res = bus.rs1_data & logic_b;
            OP_OR,  OP_ORI:  logic_res = bus.rs1_data | logic_b;
            OP_XOR, OP_XORI: logic_res = bus.rs1_data ^ logic_b;
            default:         logic_known = 1'b0;
        endcase
    end

    // Exactly one unit must be selected and its encoding must be known.
    assign illegal = (bus.uop_is_add == bus.uop_is_logic) ||
                     (bus.uop_is_add && !add_known) ||
                     (bus.uop_is_logic && !logic_known);

    always_comb begin
        result = '0;
        if (!illegal) begin
            result = bus.uop_is_add ? add_sum : logic_res;
        end
    end

`ifdef ALU_EXEC_FLAGS_EN
    assign flag_zero  = (result == '0);
    assign flag_carry = !illegal && bus.uop_is_add && add_carry;
    assign flag_ovf   = !illegal && bus.uop_is_add && add_ovf;
    assign push_entry = {flag_ovf, flag_carry, flag_zero, result};
`else
    assign push_entry = result;
`endif

    assign bus.in_ready  = !reset && (!buf_full || bus.res_ready);
    assign accept        = bus.in_valid && bus.in_ready;
    assign bus.res_valid = !buf_empty;
    assign pop           = bus.res_valid && bus.res_ready;

    alu_res_buf #(
        .WIDTH (ENTRY_W),
        .DEPTH (BUF_DEPTH)
    ) u_res_buf (
        .clk       (clk),
        .reset     (reset),
        .push      (accept),
        .push_data (push_entry),
        .pop       (pop),
        .pop_data  (head_entry),
        .full      (buf_full),
        .empty     (buf_empty)
    );

    assign bus.res_data = head_entry[XLEN-1:0];
`ifdef ALU_EXEC_FLAGS_EN
    assign bus.res_zero  = head_entry[XLEN];
    assign bus.res_carry = head_entry[XLEN+1];
    assign bus.res_ovf   = head_entry[XLEN+2];
`endif

    // Sticky: once an illegal uop is accepted the flag stays until reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            illegal_q <= 1'b0;
        end else if (accept && illegal) begin
            illegal_q <= 1'b1;
        end
    end

    assign bus.illegal_uop = illegal_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed testbench for alu_exec_unit; flag checks active with ALU_EXEC_FLAGS_EN.
module tb_alu_exec_unit;
    import alu_exec_unit_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad   = 0;

    alu_exec_if #(.XLEN(32)) bus ();

    alu_exec_unit #(.XLEN(32), .BUF_DEPTH(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        is_add;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] i;
        logic [31:0] exp;
        logic        c;
        logic        v;
    } vec_t;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_uop(input logic is_add, input logic is_logic, input logic [2:0] op,
                             input logic [31:0] a, input logic [31:0] b, input logic [31:0] i);
        bus.in_valid     = 1'b1;
        bus.uop_is_add   = is_add;
        bus.uop_is_logic = is_logic;
        bus.ctrl_adder   = op[CTRL_ADD_W-1:0];
        bus.ctrl_logic   = op;
        bus.rs1_data     = a;
        bus.rs2_data     = b;
        bus.imm          = i;
    endtask

    task automatic idle;
        bus.in_valid = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick();
        tick();
        total++;
        if (bus.in_ready !== 1'b0) begin
            bad++;
            $display("FAIL rst_in_ready got=%b want=0", bus.in_ready);
        end
        total++;
        if (bus.res_valid !== 1'b0) begin
            bad++;
            $display("FAIL rst_res_valid got=%b want=0", bus.res_valid);
        end
        total++;
        if (bus.res_data !== 32'h0) begin
            bad++;
            $display("FAIL rst_res_data got=%h want=00000000", bus.res_data);
        end
        total++;
        if (bus.illegal_uop !== 1'b0) begin
            bad++;
            $display("FAIL rst_illegal got=%b want=0", bus.illegal_uop);
        end
        reset = 1'b0;
        #1;
        total++;
        if (bus.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL rst_release_in_ready got=%b want=1", bus.in_ready);
        end
        $display("test_reset: done");
    endtask

    task automatic test_datapath;
        vec_t vecs[12];
        logic [31:0] dec_i;
        logic [31:0] dec_b;
        vecs = '{
            '{1'b1, {1'b0, OP_ADD},  32'h7FFFFFFF, 32'h00000001, 32'h0,        32'h80000000, 1'b0, 1'b1},
            '{1'b1, {1'b0, OP_SUB},  32'h00000005, 32'h00000007, 32'h0,        32'hFFFFFFFE, 1'b0, 1'b0},
            '{1'b0, OP_XORI,         32'h000000FF, 32'h0,        32'hFFFFFFFF, 32'hFFFFFF00, 1'b0, 1'b0},
            '{1'b1, {1'b0, OP_ADDI}, 32'h00000010, 32'h0,        32'hFFFFFFFF, 32'h0000000F, 1'b1, 1'b0},
            '{1'b1, {1'b0, OP_SUB},  32'h00000007, 32'h00000005, 32'h0,        32'h00000002, 1'b1, 1'b0},
            '{1'b1, {1'b0, OP_ADD},  32'hFFFFFFFF, 32'h00000001, 32'h0,        32'h00000000, 1'b1, 1'b0},
            '{1'b1, {1'b0, OP_SUB},  32'h80000000, 32'h00000001, 32'h0,        32'h7FFFFFFF, 1'b1, 1'b1},
            '{1'b0, OP_AND,          32'hF0F0F0F0, 32'hFF00FF00, 32'h0,        32'hF000F000, 1'b0, 1'b0},
            '{1'b0, OP_OR,           32'h0F0F0000, 32'h000000F0, 32'h0,        32'h0F0F00F0, 1'b0, 1'b0},
            '{1'b0, OP_ANDI,         32'h12345678, 32'h0,        32'h0000FFFF, 32'h00005678, 1'b0, 1'b0},
            '{1'b0, OP_ORI,          32'h00000000, 32'h0,        32'h80000000, 32'h80000000, 1'b0, 1'b0},
            '{1'b0, OP_XOR,          32'hAAAAAAAA, 32'hAAAAAAAA, 32'h0,        32'h00000000, 1'b0, 1'b0}
        };
        bus.res_ready = 1'b1;
        for (int k = 0; k < 12; k++) begin
            // Decoy values on the unused operand catch a wrong operand select.
            dec_b = (vecs[k].b == 32'h0) ? 32'h00000100 : vecs[k].b;
            dec_i = (vecs[k].i == 32'h0) ? 32'h00005555 : vecs[k].i;
            drive_uop(vecs[k].is_add, !vecs[k].is_add, vecs[k].op, vecs[k].a,
                      (vecs[k].i == 32'h0) ? vecs[k].b : dec_b, dec_i);
            total++;
            if (bus.in_ready !== 1'b1) begin
                bad++;
                $display("FAIL dp%0d_in_ready got=%b want=1", k, bus.in_ready);
            end
            tick();
            idle();
            total++;
            if (bus.res_valid !== 1'b1 || bus.res_data !== vecs[k].exp) begin
                bad++;
                $display("FAIL dp%0d_result got=%b/%h want=1/%h", k, bus.res_valid, bus.res_data,
                         vecs[k].exp);
            end
`ifdef ALU_EXEC_FLAGS_EN
            total++;
            if ({bus.res_zero, bus.res_carry, bus.res_ovf} !==
                {(vecs[k].exp == 32'h0), vecs[k].c, vecs[k].v}) begin
                bad++;
                $display("FAIL dp%0d_flags got=zco %b%b%b want=%b%b%b", k, bus.res_zero,
                         bus.res_carry, bus.res_ovf, (vecs[k].exp == 32'h0), vecs[k].c, vecs[k].v);
            end
`endif
            $display("test_datapath: vec %0d a=%h result=%h", k, vecs[k].a, bus.res_data);
        end
        tick();
        total++;
        if (bus.res_valid !== 1'b0) begin
            bad++;
            $display("FAIL dp_drain_valid got=%b want=0", bus.res_valid);
        end
        total++;
        if (bus.illegal_uop !== 1'b0) begin
            bad++;
            $display("FAIL dp_illegal_clear got=%b want=0", bus.illegal_uop);
        end
    endtask

    task automatic test_back_to_back;
        bus.res_ready = 1'b0;
        drive_uop(1'b1, 1'b0, {1'b0, OP_ADD}, 32'd1, 32'd2, 32'h0);
        tick();
        drive_uop(1'b1, 1'b0, {1'b0, OP_ADD}, 32'd10, 32'd20, 32'h0);
        total++;
        if (bus.res_valid !== 1'b1 || bus.res_data !== 32'd3 || bus.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL b2b_first got=v%b d%0d r%b want=v1 d3 r1", bus.res_valid,
                     bus.res_data, bus.in_ready);
        end
        tick();
        drive_uop(1'b1, 1'b0, {1'b0, OP_ADD}, 32'd100, 32'd200, 32'h0);
        total++;
        if (bus.in_ready !== 1'b0) begin
            bad++;
            $display("FAIL b2b_full_in_ready got=%b want=0", bus.in_ready);
        end
        tick();
        total++;
        if (bus.in_ready !== 1'b0 || bus.res_data !== 32'd3 || bus.res_valid !== 1'b1) begin
            bad++;
            $display("FAIL b2b_hold got=r%b v%b d%0d want=r0 v1 d3", bus.in_ready,
                     bus.res_valid, bus.res_data);
        end
        bus.res_ready = 1'b1;
        #1;
        total++;
        if (bus.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL b2b_pushpop_in_ready got=%b want=1", bus.in_ready);
        end
        tick();
        idle();
        bus.res_ready = 1'b0;
        #1;
        total++;
        if (bus.in_ready !== 1'b0 || bus.res_data !== 32'd30) begin
            bad++;
            $display("FAIL b2b_occupancy got=r%b d%0d want=r0 d30", bus.in_ready, bus.res_data);
        end
        bus.res_ready = 1'b1;
        tick();
        total++;
        if (bus.res_valid !== 1'b1 || bus.res_data !== 32'd300) begin
            bad++;
            $display("FAIL b2b_third got=v%b d%0d want=v1 d300", bus.res_valid, bus.res_data);
        end
        tick();
        total++;
        if (bus.res_valid !== 1'b0) begin
            bad++;
            $display("FAIL b2b_drained got=%b want=0", bus.res_valid);
        end
        $display("test_back_to_back: done");
    endtask

    task automatic test_illegal;
        bus.res_ready = 1'b1;
        drive_uop(1'b1, 1'b1, {1'b0, OP_ADD}, 32'd9, 32'd4, 32'h0);
        tick();
        drive_uop(1'b1, 1'b0, {1'b0, OP_ADD}, 32'd2, 32'd3, 32'h0);
        total++;
        if (bus.res_valid !== 1'b1 || bus.res_data !== 32'h0 || bus.illegal_uop !== 1'b1) begin
            bad++;
            $display("FAIL ill_both got=v%b d%h i%b want=v1 d0 i1", bus.res_valid,
                     bus.res_data, bus.illegal_uop);
        end
        tick();
        idle();
        total++;
        if (bus.res_data !== 32'd5 || bus.illegal_uop !== 1'b1) begin
            bad++;
            $display("FAIL ill_sticky got=d%0d i%b want=d5 i1", bus.res_data, bus.illegal_uop);
        end
        drive_uop(1'b0, 1'b0, OP_AND, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0);
        tick();
        idle();
        total++;
        if (bus.res_data !== 32'h0 || bus.res_valid !== 1'b1) begin
            bad++;
            $display("FAIL ill_neither got=v%b d%h want=v1 d0", bus.res_valid, bus.res_data);
        end
        tick();
        $display("test_illegal: done");
    endtask

    task automatic test_reset_mid;
        bus.res_ready = 1'b0;
        drive_uop(1'b1, 1'b0, {1'b0, OP_ADD}, 32'd4, 32'd4, 32'h0);
        tick();
        drive_uop(1'b1, 1'b0, {1'b0, OP_ADD}, 32'd6, 32'd6, 32'h0);
        tick();
        idle();
        #2;
        reset = 1'b1;
        #1;
        total++;
        if (bus.res_valid !== 1'b0 || bus.res_data !== 32'h0 || bus.in_ready !== 1'b0 ||
            bus.illegal_uop !== 1'b0) begin
            bad++;
            $display("FAIL rstmid_async got=v%b d%h r%b i%b want=v0 d0 r0 i0", bus.res_valid,
                     bus.res_data, bus.in_ready, bus.illegal_uop);
        end
        tick();
        reset = 1'b0;
        bus.res_ready = 1'b1;
        tick();
        total++;
        if (bus.res_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL rstmid_empty got=v%b r%b want=v0 r1", bus.res_valid, bus.in_ready);
        end
        $display("test_reset_mid: done");
    endtask

    task automatic test_unknown_ctrl;
        bus.res_ready = 1'b1;
        drive_uop(1'b0, 1'b1, 3'd7, 32'h5, 32'h3, 32'h0);
        tick();
        idle();
        total++;
        if (bus.res_valid !== 1'b1 || bus.res_data !== 32'h0 || bus.illegal_uop !== 1'b1) begin
            bad++;
            $display("FAIL unk_ctrl got=v%b d%h i%b want=v1 d0 i1", bus.res_valid,
                     bus.res_data, bus.illegal_uop);
        end
        tick();
        $display("test_unknown_ctrl: done");
    endtask

    initial begin
        bus.in_valid     = 1'b0;
        bus.uop_is_add   = 1'b0;
        bus.uop_is_logic = 1'b0;
        bus.ctrl_adder   = '0;
        bus.ctrl_logic   = '0;
        bus.rs1_data     = '0;
        bus.rs2_data     = '0;
        bus.imm          = '0;
        bus.res_ready    = 1'b0;
        test_reset();
        test_datapath();
        test_back_to_back();
        test_illegal();
        test_reset_mid();
        test_unknown_ctrl();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
